// File: rtl/ec551_pkg.sv
// Shared defaults and FSM state type for the image row packer.
package ec551_pkg;

    localparam int unsigned BLOCK_SIZE_DEF = 32;
    localparam int unsigned HSIZE_DEF      = 768;
    localparam int unsigned PIXEL_W_DEF    = 8;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/image_row_packer.sv
// Image row packer: assembles a row of pixels (pixel 0 in the LSBs), pairs it with the key
// captured at pixel 0, and hands it to a one-entry output holding register.
module image_row_packer
    import ec551_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int unsigned HSIZE      = HSIZE_DEF,
    parameter int unsigned PIXEL_W    = PIXEL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIXEL_W-1:0]    in_pixel,
    input  logic                  in_last,
    input  logic                  key_load,
    input  logic [BLOCK_SIZE-1:0] key_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HSIZE-1:0]      out_row,
    output logic [BLOCK_SIZE-1:0] out_key,
    output logic                  out_short,
    output logic [15:0]           row_idx
);

    localparam int unsigned NPIX  = HSIZE / PIXEL_W;
    localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [HSIZE-1:0]      buf_q, buf_d;
    logic [BLOCK_SIZE-1:0] row_key_q, row_key_d;
    logic                  buf_short_q, buf_short_d;
    logic [BLOCK_SIZE-1:0] key_q, key_d;
    logic                  out_valid_q, out_valid_d;
    logic [HSIZE-1:0]      out_row_q, out_row_d;
    logic [BLOCK_SIZE-1:0] out_key_q, out_key_d;
    logic                  out_short_q, out_short_d;
    logic [15:0]           row_idx_q, row_idx_d;

    logic                  accept, consume, can_xfer, at_last, xfer;
    logic [HSIZE-1:0]      row_asm, xfer_row;
    logic [BLOCK_SIZE-1:0] snap_key, xfer_key;
    logic                  xfer_short;

    // Ready only in FILL and never while reset is held.
    assign in_ready = rst_n && (state_q == FILL);

    // Next-state: pixel assembly, FILL/HOLD control and output register update.
    always_comb begin
        accept   = in_valid && in_ready;
        consume  = out_valid_q && out_ready;
        can_xfer = !out_valid_q || out_ready;
        at_last  = (pix_cnt_q == LAST_IDX);

        key_d    = key_load ? key_in : key_q;
        // key_d already carries key_in when key_load coincides with pixel 0.
        snap_key = (pix_cnt_q == '0) ? key_d : row_key_q;

        // The buffer is zeroed after every row, so unfilled slots stay zero.
        row_asm = buf_q;
        row_asm[int'(pix_cnt_q) * PIXEL_W +: PIXEL_W] = in_pixel;

        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        buf_d       = buf_q;
        row_key_d   = row_key_q;
        buf_short_d = buf_short_q;
        xfer        = 1'b0;
        xfer_row    = buf_q;
        xfer_key    = row_key_q;
        xfer_short  = buf_short_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (at_last || in_last) begin
                        pix_cnt_d = '0;
                        if (can_xfer) begin
                            xfer       = 1'b1;
                            xfer_row   = row_asm;
                            xfer_key   = snap_key;
                            xfer_short = !at_last;
                            buf_d      = '0;
                        end else begin
                            state_d     = HOLD;
                            buf_d       = row_asm;
                            row_key_d   = snap_key;
                            buf_short_d = !at_last;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        buf_d     = row_asm;
                        row_key_d = snap_key;
                    end
                end
            end
            HOLD: begin
                if (can_xfer) begin
                    xfer    = 1'b1;
                    buf_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        out_valid_d = xfer || (out_valid_q && !consume);
        out_row_d   = xfer ? xfer_row : out_row_q;
        out_key_d   = xfer ? xfer_key : out_key_q;
        out_short_d = xfer ? xfer_short : out_short_q;
        row_idx_d   = row_idx_q + {15'd0, consume};
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            pix_cnt_q   <= '0;
            buf_q       <= '0;
            row_key_q   <= '0;
            buf_short_q <= 1'b0;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_key_q   <= '0;
            out_short_q <= 1'b0;
            row_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            buf_q       <= buf_d;
            row_key_q   <= row_key_d;
            buf_short_q <= buf_short_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_key_q   <= out_key_d;
            out_short_q <= out_short_d;
            row_idx_q   <= row_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_key   = out_key_q;
    assign out_short = out_short_q;
    assign row_idx   = row_idx_q;

endmodule

// File: tb/tb_image_row_packer.sv
// Directed self-checking bench for image_row_packer (HSIZE=64, PIXEL_W=8, BLOCK_SIZE=32).
module tb_image_row_packer;

    localparam int unsigned BLOCK_SIZE = 32;
    localparam int unsigned HSIZE      = 64;
    localparam int unsigned PIXEL_W    = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [PIXEL_W-1:0]    in_pixel;
    logic                  in_last;
    logic                  key_load;
    logic [BLOCK_SIZE-1:0] key_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [HSIZE-1:0]      out_row;
    logic [BLOCK_SIZE-1:0] out_key;
    logic                  out_short;
    logic [15:0]           row_idx;

    int num_checks;
    int num_errors;

    image_row_packer #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .HSIZE      (HSIZE),
        .PIXEL_W    (PIXEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_last   (in_last),
        .key_load  (key_load),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_key   (out_key),
        .out_short (out_short),
        .row_idx   (row_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and wait (bounded) until it is accepted.
    task automatic send_pixel(input logic [7:0] pix, input logic last, input logic kl,
                              input logic [31:0] ki);
        int waited;
        in_valid = 1'b1;
        in_pixel = pix;
        in_last  = last;
        key_load = kl;
        key_in   = ki;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            num_checks++;
            num_errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for pixel 0x%0h", pix);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        key_load = 1'b0;
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_pixel   = '0;
        in_last    = 1'b0;
        key_load   = 1'b0;
        key_in     = '0;
        out_ready  = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_row_idx", {48'd0, row_idx}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Full row with a preloaded key
        key_load = 1'b1;
        key_in   = 32'hA5A5_A5A5;
        tick();
        key_load = 1'b0;
        for (int i = 1; i <= 8; i++) send_pixel(8'(i), 1'b0, 1'b0, 32'd0);
        check("full_valid", {63'd0, out_valid}, 64'd1);
        check("full_row", out_row, 64'h0807_0605_0403_0201);
        check("full_key", {32'd0, out_key}, 64'hA5A5_A5A5);
        check("full_short", {63'd0, out_short}, 64'd0);
        tick();
        check("full_row_idx", {48'd0, row_idx}, 64'd1);
        check("full_drained", {63'd0, out_valid}, 64'd0);

        // Early-closed row is zero-padded
        send_pixel(8'h11, 1'b0, 1'b0, 32'd0);
        send_pixel(8'h22, 1'b0, 1'b0, 32'd0);
        send_pixel(8'h33, 1'b1, 1'b0, 32'd0);
        check("short_row", out_row, 64'h0000_0000_0033_2211);
        check("short_flag", {63'd0, out_short}, 64'd1);
        check("short_key", {32'd0, out_key}, 64'hA5A5_A5A5);
        tick();

        // in_last on the final slot is a full row
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h91 + i), (i == 7), 1'b0, 32'd0);
        check("lastfull_row", out_row, 64'h9897_9695_9493_9291);
        check("lastfull_short", {63'd0, out_short}, 64'd0);
        tick();
        check("lastfull_row_idx", {48'd0, row_idx}, 64'd3);

        // Backpressure: second row parks until the first is consumed
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h21 + i), 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h31 + i), 1'b0, 1'b0, 32'd0);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_hold_row", out_row, 64'h2827_2625_2423_2221);
        tick();
        tick();
        check("bp_stable_valid", {63'd0, out_valid}, 64'd1);
        check("bp_stable_row", out_row, 64'h2827_2625_2423_2221);
        check("bp_no_consume", {48'd0, row_idx}, 64'd3);
        out_ready = 1'b1;
        tick();
        check("bp_second_valid", {63'd0, out_valid}, 64'd1);
        check("bp_second_row", out_row, 64'h3837_3635_3433_3231);
        check("bp_row_idx", {48'd0, row_idx}, 64'd4);
        check("bp_ready_again", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp_drained_idx", {48'd0, row_idx}, 64'd5);

        // Key snapshot at pixel 0; mid-row key_load goes to the next row
        for (int i = 0; i < 8; i++)
            send_pixel(8'(8'h40 + i), 1'b0, (i == 0 || i == 4), (i == 0) ? 32'h1 : 32'h2);
        check("key_row0", {32'd0, out_key}, 64'h1);
        check("key_row0_data", out_row, 64'h4746_4544_4342_4140);
        tick();
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h50 + i), 1'b0, 1'b0, 32'd0);
        check("key_row1", {32'd0, out_key}, 64'h2);
        tick();

        // Reset mid-row discards the partial row
        for (int i = 0; i < 5; i++) send_pixel(8'(8'h61 + i), 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_row", out_row, 64'd0);
        check("mid_rst_key", {32'd0, out_key}, 64'd0);
        check("mid_rst_short", {63'd0, out_short}, 64'd0);
        check("mid_rst_idx", {48'd0, row_idx}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_pixel(8'(8'h71 + i), 1'b0, 1'b0, 32'd0);
        check("post_rst_row", out_row, 64'h7877_7675_7473_7271);
        check("post_rst_key", {32'd0, out_key}, 64'd0);
        tick();
        check("post_rst_idx", {48'd0, row_idx}, 64'd1);

        // row_idx wraps after 65536 consumes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 65535; i++) send_pixel(8'(i), 1'b1, 1'b0, 32'd0);
        tick();
        tick();
        check("wrap_pre", {48'd0, row_idx}, 64'hFFFF);
        send_pixel(8'hEE, 1'b1, 1'b0, 32'd0);
        tick();
        check("wrap_zero", {48'd0, row_idx}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/image_row_packer.md
IMAGE_ROW_PACKER -- requirements
Module: image_row_packer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32: key width, matching the downstream ECB stage.
REQ-002 SHALL have parameter HSIZE, default 768: row width in bits.
REQ-003 SHALL have parameter PIXEL_W, default 8: pixel width in bits; HSIZE SHALL be a multiple of PIXEL_W; NPIX = HSIZE/PIXEL_W.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: pixel present.
REQ-007 SHALL have port in_ready, output, 1: pixel accepted when in_valid && in_ready.
REQ-008 SHALL have port in_pixel, input, PIXEL_W: pixel data.
REQ-009 SHALL have port in_last, input, 1: last pixel of the line, qualified by acceptance.
REQ-010 SHALL have port key_load, input, 1: load key_in into the key register.
REQ-011 SHALL have port key_in, input, BLOCK_SIZE: new key.
REQ-012 SHALL have port out_valid, output, 1: assembled row available.
REQ-013 SHALL have port out_ready, input, 1: row consumed when out_valid && out_ready.
REQ-014 SHALL have port out_row, output, HSIZE: row, feeding the ECB stage image_row.
REQ-015 SHALL have port out_key, output, BLOCK_SIZE: key paired with out_row.
REQ-016 SHALL have port out_short, output, 1: row closed early by in_last and zero-padded.
REQ-017 SHALL have port row_idx, output, 16: count of rows emitted, wraps 0xFFFF->0.

Function
REQ-018 SHALL place pixel k of a row at out_row[k*PIXEL_W +: PIXEL_W]; pixel 0 goes in the LSBs.
REQ-019 SHALL track pixel index pix_cnt in 0..NPIX-1 and increment it on each acceptance.
REQ-020 SHALL complete a row on acceptance of pixel NPIX-1, or on acceptance of any pixel with in_last=1; on completion pix_cnt returns to 0.
REQ-021 SHALL zero all unfilled pixel slots of an early-closed row and set out_short=1 for it; in_last on pixel NPIX-1 SHALL give out_short=0.
REQ-022 SHALL run an FSM with states FILL and HOLD; reset enters FILL.
REQ-023 FILL: in_ready=1. On completion, if the holding register is empty or is being consumed in the same cycle, the row SHALL transfer and out_valid SHALL be 1 on the next cycle (latency 1); otherwise the FSM SHALL go to HOLD.
REQ-024 HOLD: in_ready=0. The FSM SHALL go to FILL and transfer the row in the cycle the holding register is empty or being consumed.
REQ-025 SHALL hold out_valid, out_row, out_key and out_short stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid after a consume with no transfer in the same cycle, and SHALL increment row_idx by 1 per consume.
REQ-027 key_load SHALL update the key register at the clock edge, independent of FSM state.
REQ-028 SHALL snapshot the row key from the key register when pixel 0 of a row is accepted; key_load in that same cycle SHALL supply key_in to the snapshot.
REQ-029 SHALL output the snapshot of the row currently held on out_key; later key_load SHALL NOT alter a row already in progress.
REQ-030 SHALL NOT accept any pixel while in_ready=0; upstream SHALL keep the pixel presented.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously clear out_valid, out_row, out_key, out_short, row_idx, pix_cnt, the key register and the assembly buffer, and SHALL set FSM=FILL.
REQ-032 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-033 Reset mid-row or mid-hold SHALL discard the partial or held row with no emission.

Structure
REQ-034 Package ec551_pkg SHALL hold the BLOCK_SIZE, HSIZE and PIXEL_W defaults and the FSM state typedef (FILL, HOLD).
REQ-035 SHALL be a single module with no sub-modules; its output feeds ebc_mode directly.

Verification (bench params: HSIZE=64, PIXEL_W=8, BLOCK_SIZE=32, NPIX=8)
REQ-036 key_load with key_in=0xA5A5A5A5, then pixels 0x01..0x08, out_ready=1 -> one cycle after pixel 8: out_valid=1, out_row=0x0807060504030201, out_key=0xA5A5A5A5, out_short=0, row_idx becomes 1.
REQ-037 Pixels 0x11,0x22,0x33 with in_last on 0x33 -> out_row=0x0000000000332211, out_short=1.
REQ-038 out_ready=0, two full rows sent -> first row held stable; in_ready=0 after the 16th pixel; raise out_ready -> row 1 consumed, row 2 appears next cycle with no data loss.
REQ-039 key_load 0x1 in the same cycle as pixel 0, then key_load 0x2 at pixel 4 -> row gets out_key=0x1; next row gets 0x2.
REQ-040 Reset asserted after pixel 5 -> all outputs are 0; an 8-pixel row after release emits only the new pixels.
REQ-041 Preload row_idx to 0xFFFF through 65535 consumes, then one more consume -> row_idx=0x0000.
